gen1_tx_scheduler: RTL and testbench
====================================

Name: gen1_tx_scheduler

Overview:
Gen1 transmit-side scheduler that feeds the 32-bit Gen1 scrambler (4 symbols/cycle, lane-0 symbol in bits [7:0]).
Arbitrates between three sources:
- link-layer packet stream (valid/ready)
- LTSSM ordered-set requests (16-symbol TS1/TS2 etc.)
- internal SKP-interval timer

Fills unused cycles with logical idle. Sits between the link layer / LTSSM and gen1_scramble.

Parameters:
SKP_INTERVAL_CYC, 295, cycles between SKP requests (1180 symbols / 4)
OS_BEATS, 4, beats per ordered set (16 symbols / 4)

Ports:
clk_i  in  1  100 MHz clock
rst_ni  in  1  asynchronous active-low reset
tx_enable_i  in  1  transmit enable from LTSSM
pkt_data_i  in  32  link-layer symbols
pkt_k_i  in  4  per-symbol K flags
pkt_valid_i  in  1  beat valid
pkt_last_i  in  1  final beat of packet
pkt_ready_o  out  1  beat accepted when valid&ready
os_req_i  in  1  ordered-set request (level, held until os_done_o)
os_data_i  in  128  16 OS symbols, symbol 0 in [7:0]
os_k_i  in  16  OS K flags
os_done_o  out  1  one-cycle pulse on cycle the last OS beat is emitted
scr_data_o  out  32  to scrambler data_in_i
scr_k_o  out  4  to scrambler data_k_in_i
scr_valid_o  out  1  to scrambler data_valid_i
pipe_width_o  out  6  constant 6'd32
skp_sent_o  out  1  pulse when SKP OS emitted
underrun_o  out  1  pulse: pkt_valid_i low mid-packet

Behaviour:
- Async reset values:
  - all outputs 0 except pipe_width_o=32
  - state IDLE, SKP counter 0, skp_pending 0
- All scr_* outputs are registered: 1-cycle latency from selection to scr_*.
- Only reachable values on scr_valid_o: 1 whenever tx_enable_i was high at selection, 0 otherwise.
- States and transitions:
  - IDLE: packet boundary; arbitration point.
  - PKT: mid-packet.
  - OS: beat counter 0..OS_BEATS-1.
  - SKP: single beat.
- IDLE arbitration, evaluated each cycle with tx_enable_i=1; fixed priority:
  1. skp_pending → SKP.
  2. os_req_i → OS.
  3. pkt_valid_i → accept beat; go PKT unless pkt_last_i.
  4. Otherwise emit logical idle: data 0, k 0.
- SKP beat:
  - emits {SKP,SKP,SKP,COM}, k=4'hF (COM on lane 0, resets the scrambler LFSR)
  - clears skp_pending, pulses skp_sent_o, returns to IDLE
- OS:
  - beat n emits os_data_i[32n+:32] and os_k_i[4n+:4]
  - os_data_i/os_k_i are sampled live and must stay stable while os_req_i is high
  - last beat pulses os_done_o, returns to IDLE
  - not preemptible by SKP
- PKT:
  - pkt_ready_o=1, independent of skp_pending or os_req_i
  - beat with pkt_last_i returns to IDLE
  - pkt_valid_i=0 in PKT: emit logical idle, pulse underrun_o, stay PKT
- pkt_ready_o is combinational. It is 1 only when:
  - tx_enable_i=1, and
  - state PKT, or state IDLE with no skp_pending and no os_req_i
- SKP timer:
  - counts while tx_enable_i=1; holds when disabled
  - at SKP_INTERVAL_CYC-1: wraps to 0 and sets skp_pending
  - expiry while already pending: no accumulation (see optional feature)
- Simultaneous timer expiry and SKP emission in the same cycle: pending stays set (new request wins).
- tx_enable_i deassert:
  - mid-OS or mid-PKT: current OS/packet completes (underrun rules still apply)
  - then IDLE with scr_valid_o=0, pkt_ready_o=0
- Reset asserted mid-OS or mid-packet: immediate abort, no os_done_o.

Optional Feature:
TX_SKP_DEBT_EN
- Defined:
  - skp_pending becomes a 2-bit owed counter, saturating at 3
  - each expiry increments it; each SKP beat decrements it
  - owed SKPs are sent back-to-back at the next boundary
  - expiry and emission in the same cycle leave the count unchanged
- Undefined: single pending flag; extra expiries are dropped.

Decomposition:
- pcie_phy_pkg additions:
  - SKP symbol constant (K28.0, 8'h1C), alongside the existing COM
  - SKP_OS_BEAT constant (32'h1C1C1CBC, k 4'hF)
  - tx_sched_state_e enum {IDLE, PKT, OS, SKP}
- Sub-module gen1_skp_timer:
  - counter plus pending/debt logic (holds the TX_SKP_DEBT_EN variant)
  - ports: clk_i, rst_ni, en_i, skp_taken_i, skp_pending_o
- FSM and output mux remain in gen1_tx_scheduler.

Test Plan:
- Reset, tx_enable_i=1, no requests, SKP_INTERVAL_CYC=8 → idle beats (data 0, k 0, valid 1); at cycle 9 scr_data_o=32'h1C1C1CBC, k=4'hF, skp_sent_o pulses.
- os_req_i with TS1 pattern (COM, then 15 symbols 8'h4A…) → 4 consecutive beats matching os_data_i slices; os_done_o coincides with beat 4; os_req_i dropped → idle.
- 5-beat packet mid-stream with SKP expiry at beat 2 → all 5 beats contiguous, SKP beat immediately after pkt_last_i beat, pkt_ready_o low that cycle.
- os_req_i and pkt_valid_i and skp_pending together in IDLE → order SKP, OS (4 beats), then packet.
- pkt_valid_i dropped for 2 cycles mid-packet → 2 idle beats, underrun_o pulses twice, packet resumes in PKT.
- TX_SKP_DEBT_EN, 8-beat OS requests back-to-back across 2 expiries → two SKP beats sent consecutively at next boundary; rst_ni pulsed mid-OS → all outputs 0 asynchronously, no os_done_o.

Source files
------------

// File: rtl/pcie_phy_pkg.sv
// Shared Gen1 PHY symbols, ordered-set constants and TX scheduler types.
package pcie_phy_pkg;

  localparam logic [7:0]  COM_SYM     = 8'hBC;  // K28.5
  localparam logic [7:0]  SKP_SYM     = 8'h1C;  // K28.0
  localparam logic [31:0] SKP_OS_BEAT = {SKP_SYM, SKP_SYM, SKP_SYM, COM_SYM};
  localparam logic [3:0]  SKP_OS_K    = 4'hF;
  localparam logic [5:0]  PIPE_WIDTH  = 6'd32;

  typedef enum logic [1:0] {IDLE, PKT, OS, SKP} tx_sched_state_e;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  k;
  } tx_beat_t;

endpackage

// File: rtl/gen1_skp_timer.sv
// SKP interval timer and pending/owed tracking.
// TX_SKP_DEBT_EN: owed SKPs are counted (saturating at 3) instead of dropped.
module gen1_skp_timer #(
  parameter int SKP_INTERVAL_CYC = 295
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic skp_taken_i,
  output logic skp_pending_o
);

  localparam int CW = (SKP_INTERVAL_CYC > 1) ? $clog2(SKP_INTERVAL_CYC) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_expire;

  assign w_expire = en_i && (r_cnt == CW'(SKP_INTERVAL_CYC - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   r_cnt <= '0;
    else if (en_i) r_cnt <= w_expire ? '0 : r_cnt + 1'b1;
  end

`ifdef TX_SKP_DEBT_EN
  logic [1:0] r_owed;

  // Expiry together with an emitted SKP cancels out.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_owed <= 2'd0;
    else begin
      case ({w_expire, skp_taken_i})
        2'b10:   if (r_owed != 2'd3) r_owed <= r_owed + 2'd1;
        2'b01:   if (r_owed != 2'd0) r_owed <= r_owed - 2'd1;
        default: r_owed <= r_owed;
      endcase
    end
  end

  assign skp_pending_o = |r_owed;
`else
  logic r_pending;

  // A fresh expiry wins over the SKP being emitted in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)          r_pending <= 1'b0;
    else if (w_expire)    r_pending <= 1'b1;
    else if (skp_taken_i) r_pending <= 1'b0;
  end

  assign skp_pending_o = r_pending;
`endif

endmodule

// File: rtl/gen1_tx_scheduler.sv
// Gen1 TX scheduler: arbitrates SKP / ordered sets / packets into the scrambler.
// Optional TX_SKP_DEBT_EN (in gen1_skp_timer) queues missed SKPs.
module gen1_tx_scheduler
  import pcie_phy_pkg::*;
#(
  parameter int SKP_INTERVAL_CYC = 295,
  parameter int OS_BEATS         = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    tx_enable_i,
  input  logic [31:0]             pkt_data_i,
  input  logic [3:0]              pkt_k_i,
  input  logic                    pkt_valid_i,
  input  logic                    pkt_last_i,
  output logic                    pkt_ready_o,
  input  logic                    os_req_i,
  input  logic [32*OS_BEATS-1:0]  os_data_i,
  input  logic [4*OS_BEATS-1:0]   os_k_i,
  output logic                    os_done_o,
  output logic [31:0]             scr_data_o,
  output logic [3:0]              scr_k_o,
  output logic                    scr_valid_o,
  output logic [5:0]              pipe_width_o,
  output logic                    skp_sent_o,
  output logic                    underrun_o
);

  localparam int BW = (OS_BEATS > 1) ? $clog2(OS_BEATS) : 1;

  tx_sched_state_e r_state, w_state_nxt;
  logic [BW-1:0]   r_os_beat, w_os_beat_nxt;
  tx_beat_t        w_beat;
  logic            w_pending, w_skp_taken, w_und, w_os_done;

  gen1_skp_timer #(.SKP_INTERVAL_CYC(SKP_INTERVAL_CYC)) u_skp_timer (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .en_i          (tx_enable_i),
    .skp_taken_i   (w_skp_taken),
    .skp_pending_o (w_pending)
  );

  // The IDLE arbitration cycle emits the first beat of whatever it picks,
  // so back-to-back SKP/OS/packet traffic has no bubbles.
  always_comb begin
    w_state_nxt   = r_state;
    w_os_beat_nxt = r_os_beat;
    w_beat        = '0;
    w_skp_taken   = 1'b0;
    w_und         = 1'b0;
    w_os_done     = 1'b0;
    case (r_state)
      IDLE: begin
        if (tx_enable_i) begin
          if (w_pending) begin
            w_beat      = '{data: SKP_OS_BEAT, k: SKP_OS_K};
            w_skp_taken = 1'b1;
          end else if (os_req_i) begin
            w_beat = '{data: os_data_i[31:0], k: os_k_i[3:0]};
            if (OS_BEATS == 1) w_os_done = 1'b1;
            else begin
              w_state_nxt   = OS;
              w_os_beat_nxt = BW'(1);
            end
          end else if (pkt_valid_i) begin
            w_beat = '{data: pkt_data_i, k: pkt_k_i};
            if (!pkt_last_i) w_state_nxt = PKT;
          end
        end
      end
      OS: begin
        w_beat = '{data: os_data_i[{r_os_beat, 5'd0} +: 32],
                   k:    os_k_i[{r_os_beat, 2'd0} +: 4]};
        if (r_os_beat == BW'(OS_BEATS - 1)) begin
          w_os_done     = 1'b1;
          w_state_nxt   = IDLE;
          w_os_beat_nxt = '0;
        end else begin
          w_os_beat_nxt = r_os_beat + 1'b1;
        end
      end
      PKT: begin
        if (tx_enable_i) begin
          if (pkt_valid_i) begin
            w_beat = '{data: pkt_data_i, k: pkt_k_i};
            if (pkt_last_i) w_state_nxt = IDLE;
          end else begin
            w_und = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_os_beat   <= '0;
      scr_data_o  <= '0;
      scr_k_o     <= '0;
      scr_valid_o <= 1'b0;
      skp_sent_o  <= 1'b0;
      underrun_o  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_os_beat   <= w_os_beat_nxt;
      scr_data_o  <= w_beat.data;
      scr_k_o     <= w_beat.k;
      scr_valid_o <= tx_enable_i;
      skp_sent_o  <= w_skp_taken;
      underrun_o  <= w_und;
    end
  end

  // os_done_o is combinational so the requester can drop os_req_i before
  // the next IDLE arbitration sees it.
  assign os_done_o    = w_os_done;
  assign pkt_ready_o  = rst_ni && tx_enable_i &&
                        ((r_state == PKT) ||
                         ((r_state == IDLE) && !w_pending && !os_req_i));
  assign pipe_width_o = PIPE_WIDTH;

endmodule

// File: tb/tb_gen1_tx_scheduler.sv
// Self-checking bench for gen1_tx_scheduler (SKP interval shortened to 8).
module tb_gen1_tx_scheduler;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         tx_enable_i;
  logic [31:0]  pkt_data_i;
  logic [3:0]   pkt_k_i;
  logic         pkt_valid_i, pkt_last_i, pkt_ready_o;
  logic         os_req_i, os_done_o;
  logic [127:0] os_data_i;
  logic [15:0]  os_k_i;
  logic [31:0]  scr_data_o;
  logic [3:0]   scr_k_o;
  logic         scr_valid_o, skp_sent_o, underrun_o;
  logic [5:0]   pipe_width_o;

  gen1_tx_scheduler #(.SKP_INTERVAL_CYC(8), .OS_BEATS(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .tx_enable_i(tx_enable_i),
    .pkt_data_i(pkt_data_i), .pkt_k_i(pkt_k_i), .pkt_valid_i(pkt_valid_i),
    .pkt_last_i(pkt_last_i), .pkt_ready_o(pkt_ready_o),
    .os_req_i(os_req_i), .os_data_i(os_data_i), .os_k_i(os_k_i),
    .os_done_o(os_done_o), .scr_data_o(scr_data_o), .scr_k_o(scr_k_o),
    .scr_valid_o(scr_valid_o), .pipe_width_o(pipe_width_o),
    .skp_sent_o(skp_sent_o), .underrun_o(underrun_o)
  );

  always #5 clk_i = ~clk_i;

  localparam logic [127:0] TS1_D = {{15{8'h4A}}, 8'hBC};
  localparam logic [15:0]  TS1_K = 16'h0001;
  localparam logic [127:0] P2_D  = 128'h1F1E1D1C_1B1A1918_17161514_13121110;
  localparam logic [15:0]  P2_K  = 16'h8421;
  localparam logic [31:0]  SKPD  = 32'h1C1C1CBC;

  typedef struct {
    logic en, osr; logic [127:0] od; logic [15:0] ok;
    logic pv, pl; logic [31:0] pd; logic [3:0] pk;
    logic rdy, done;
    logic [31:0] bd; logic [3:0] bk; logic bv, bs, bu;
  } vec_t;

  typedef struct packed {
    logic [31:0] d; logic [3:0] k; logic v, s, u; int unsigned cyc;
  } beat_t;

  vec_t  vecs[$];
  beat_t sb[$];
  int    total = 0;
  int    bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic en, osr, input logic [127:0] od,
                              input logic [15:0] ok, input logic pv, pl,
                              input logic [31:0] pd, input logic [3:0] pk,
                              input logic rdy, done, input logic [31:0] bd,
                              input logic [3:0] bk, input logic bv, bs, bu);
    vec_t v;
    v.en = en; v.osr = osr; v.od = od; v.ok = ok; v.pv = pv; v.pl = pl;
    v.pd = pd; v.pk = pk; v.rdy = rdy; v.done = done;
    v.bd = bd; v.bk = bk; v.bv = bv; v.bs = bs; v.bu = bu;
    return v;
  endfunction

  function automatic vec_t v_idle();
    return mk(1, 0, '0, '0, 0, 0, '0, '0, 1, 0, '0, '0, 1, 0, 0);
  endfunction

  function automatic vec_t v_skp();
    return mk(1, 0, '0, '0, 0, 0, '0, '0, 0, 0, SKPD, 4'hF, 1, 1, 0);
  endfunction

  task automatic apply(input vec_t v);
    tx_enable_i = v.en; os_req_i = v.osr; os_data_i = v.od; os_k_i = v.ok;
    pkt_valid_i = v.pv; pkt_last_i = v.pl; pkt_data_i = v.pd; pkt_k_i = v.pk;
  endtask

  task automatic pop_check();
    beat_t b;
    if (sb.size() == 0) return;
    b = sb.pop_front();
    chk($sformatf("c%0d_data", b.cyc), scr_data_o, b.d);
    chk($sformatf("c%0d_k", b.cyc), scr_k_o, b.k);
    chk($sformatf("c%0d_valid", b.cyc), scr_valid_o, b.v);
    chk($sformatf("c%0d_skp_sent", b.cyc), skp_sent_o, b.s);
    chk($sformatf("c%0d_underrun", b.cyc), underrun_o, b.u);
  endtask

  initial begin
    logic [31:0] d;
    // c1-8 idle, c9 SKP, c10 idle
    for (int i = 0; i < 8; i++) vecs.push_back(v_idle());
    vecs.push_back(v_skp());
    vecs.push_back(v_idle());
    // c11-14 TS1 ordered set
    vecs.push_back(mk(1, 1, TS1_D, TS1_K, 0, 0, '0, '0, 0, 0, 32'h4A4A4ABC, 4'h1, 1, 0, 0));
    for (int i = 1; i < 4; i++)
      vecs.push_back(mk(1, 1, TS1_D, TS1_K, 0, 0, '0, '0, 0, i == 3, 32'h4A4A4A4A, 4'h0, 1, 0, 0));
    vecs.push_back(v_idle()); vecs.push_back(v_idle());   // c15-16
    vecs.push_back(v_skp());                              // c17
    for (int i = 0; i < 5; i++) vecs.push_back(v_idle()); // c18-22
    // c23-27 five-beat packet, expiry lands at c24; SKP follows at c28
    for (int i = 0; i < 5; i++) begin
      d = 32'hA0000000 + i;
      vecs.push_back(mk(1, 0, '0, '0, 1, i == 4, d, d[3:0], 1, 0, d, d[3:0], 1, 0, 0));
    end
    vecs.push_back(v_skp());                              // c28
    for (int i = 0; i < 4; i++) vecs.push_back(v_idle()); // c29-32
    // c33 SKP + OS + packet all pending: SKP first
    vecs.push_back(mk(1, 1, P2_D, P2_K, 1, 0, 32'hB0000001, 4'h0, 0, 0, SKPD, 4'hF, 1, 1, 0));
    for (int i = 0; i < 4; i++) begin                    // c34-37
      d = P2_D[32*i +: 32];
      vecs.push_back(mk(1, 1, P2_D, P2_K, 1, 0, 32'hB0000001, 4'h0, 0, i == 3,
                        d, P2_K[4*i +: 4], 1, 0, 0));
    end
    vecs.push_back(mk(1, 0, '0, '0, 1, 0, 32'hB0000001, 4'h0, 1, 0, 32'hB0000001, 4'h0, 1, 0, 0));
    vecs.push_back(mk(1, 0, '0, '0, 1, 1, 32'hB0000002, 4'h2, 1, 0, 32'hB0000002, 4'h2, 1, 0, 0));
    vecs.push_back(v_idle());                             // c40
    vecs.push_back(v_skp());                              // c41
    vecs.push_back(v_idle());                             // c42
    // c43-47 packet with two-cycle underrun
    vecs.push_back(mk(1, 0, '0, '0, 1, 0, 32'hC0000001, 4'h1, 1, 0, 32'hC0000001, 4'h1, 1, 0, 0));
    for (int i = 0; i < 2; i++)
      vecs.push_back(mk(1, 0, '0, '0, 0, 0, 32'hDEADBEEF, 4'hF, 1, 0, '0, '0, 1, 0, 1));
    vecs.push_back(mk(1, 0, '0, '0, 1, 0, 32'hC0000002, 4'h0, 1, 0, 32'hC0000002, 4'h0, 1, 0, 0));
    vecs.push_back(mk(1, 0, '0, '0, 1, 1, 32'hC0000003, 4'h0, 1, 0, 32'hC0000003, 4'h0, 1, 0, 0));
    vecs.push_back(v_idle());                             // c48
    vecs.push_back(v_skp());                              // c49
    // c50-71 long packet spanning expiries at c56, c64; c72 SKP with expiry
    for (int i = 0; i < 22; i++) begin
      d = 32'hD0000000 + i;
      vecs.push_back(mk(1, 0, '0, '0, 1, i == 21, d, d[3:0], 1, 0, d, d[3:0], 1, 0, 0));
    end
    vecs.push_back(v_skp());                              // c72
    vecs.push_back(v_skp());                              // c73
`ifdef TX_SKP_DEBT_EN
    vecs.push_back(v_skp());                              // c74
`else
    vecs.push_back(v_idle());
`endif
    vecs.push_back(v_idle());                             // c75
    // c76-79 OS with tx_enable dropped after first beat
    for (int i = 0; i < 4; i++) begin
      d = P2_D[32*i +: 32];
      vecs.push_back(mk(i == 0, 1, P2_D, P2_K, 0, 0, '0, '0, 0, i == 3,
                        d, P2_K[4*i +: 4], i == 0, 0, 0));
    end
    // c80 disabled IDLE ignores a valid packet beat
    vecs.push_back(mk(0, 0, '0, '0, 1, 0, 32'hE0000001, 4'h1, 0, 0, '0, '0, 0, 0, 0));

    rst_ni = 1'b0;
    apply(mk(1, 0, '0, '0, 0, 0, '0, '0, 0, 0, '0, '0, 0, 0, 0));
    #3;
    chk("rst_data", scr_data_o, 32'h0);
    chk("rst_valid", scr_valid_o, 1'b0);
    chk("rst_ready", pkt_ready_o, 1'b0);
    chk("rst_pipe_width", pipe_width_o, 6'd32);
    tx_enable_i = 1'b0;
    @(posedge clk_i); @(posedge clk_i); #2;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    foreach (vecs[i]) begin
      apply(vecs[i]);
      @(negedge clk_i);
      chk($sformatf("c%0d_ready", i + 1), pkt_ready_o, vecs[i].rdy);
      chk($sformatf("c%0d_os_done", i + 1), os_done_o, vecs[i].done);
      pop_check();
      sb.push_back('{d: vecs[i].bd, k: vecs[i].bk, v: vecs[i].bv,
                     s: vecs[i].bs, u: vecs[i].bu, cyc: i + 1});
      @(posedge clk_i); #1;
    end
    apply(mk(0, 0, '0, '0, 0, 0, '0, '0, 0, 0, '0, '0, 0, 0, 0));
    @(negedge clk_i);
    pop_check();
    chk("sb_drained", sb.size(), 0);
    @(posedge clk_i); #1;

    // Reset asserted mid-OS: outputs clear at once, no os_done, OS restarts
    apply(mk(1, 1, P2_D, P2_K, 0, 0, '0, '0, 0, 0, '0, '0, 0, 0, 0));
    @(negedge clk_i); chk("ros_b0_done", os_done_o, 1'b0);
    @(posedge clk_i); #1;
    @(negedge clk_i); chk("ros_b1_done", os_done_o, 1'b0);
    @(posedge clk_i); #1;
    chk("ros_b1_data", scr_data_o, 32'h17161514);
    #1 rst_ni = 1'b0;
    #1;
    chk("ros_rst_data", scr_data_o, 32'h0);
    chk("ros_rst_k", scr_k_o, 4'h0);
    chk("ros_rst_valid", scr_valid_o, 1'b0);
    chk("ros_rst_done", os_done_o, 1'b0);
    chk("ros_rst_ready", pkt_ready_o, 1'b0);
    chk("ros_rst_pipe", pipe_width_o, 6'd32);
    #1 rst_ni = 1'b1;
    @(negedge clk_i);
    chk("ros_post_done", os_done_o, 1'b0);
    chk("ros_post_ready", pkt_ready_o, 1'b0);
    @(posedge clk_i); #1;
    chk("ros_restart_data", scr_data_o, 32'h13121110);
    chk("ros_restart_k", scr_k_o, 4'h1);
    chk("ros_restart_valid", scr_valid_o, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
